// File: rtl/mrc_pipe_sequencer.sv
// Issue/retire controller for the fixed-latency MRC correction pipeline.
// A valid/tag shift register tracks in-flight words; credits bound in-flight plus queued results to the FIFO depth.
module mrc_pipe_sequencer #(
  parameter int PIPE_LAT   = 12,
  parameter int DATA_W     = 18,
  parameter int SGN_W      = 10,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              in_ready,
  input  logic              flush,
  output logic              pipe_issue,
  input  logic [DATA_W-1:0] pipe_d6,
  input  logic [SGN_W-1:0]  pipe_sgn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_d6,
  output logic [SGN_W-1:0]  out_sgn,
  output logic              busy,
  output logic              ovf_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W + SGN_W;

  logic [PIPE_LAT-1:0] vld_p;
  logic [TAG_W-1:0]    tag_p [PIPE_LAT];
  logic [ENT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    inflight, fifo_count, credits;
  logic                issue, capture, pop, wr_en;

  assign credits    = CNT_W'(FIFO_DEPTH) - inflight - fifo_count;
  assign in_ready   = (credits != '0) & ~flush;
  assign issue      = in_valid & in_ready;
  assign pipe_issue = issue;
  assign capture    = vld_p[PIPE_LAT-1];
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid & out_ready;
  // A full FIFO only accepts a capture when the head leaves in the same cycle.
  assign wr_en      = capture & ((fifo_count != CNT_W'(FIFO_DEPTH)) | pop);
  assign busy       = (inflight != '0) | (fifo_count != '0);

  assign {out_tag, out_d6, out_sgn} = out_valid ? mem[rd_ptr] : '0;

  // Control state: issue tracking, FIFO pointers and occupancy counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      vld_p      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= '0;
      fifo_count <= '0;
    end else begin
      vld_p <= {vld_p[PIPE_LAT-2:0], issue};
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({issue, capture})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 ovf_err <= 1'b0;
    else if (capture & ~wr_en) ovf_err <= 1'b1;
  end

  // Data path: tag shift register and FIFO storage carry no reset
  always_ff @(posedge clk) begin
    tag_p[0] <= in_tag;
    for (int i = 1; i < PIPE_LAT; i++) tag_p[i] <= tag_p[i-1];
    if (wr_en) mem[wr_ptr] <= {tag_p[PIPE_LAT-1], pipe_d6, pipe_sgn};
  end

endmodule

// File: tb/tb_mrc_pipe_sequencer.sv
// Randomized bench for mrc_pipe_sequencer against a queue-based transaction model.
module tb_mrc_pipe_sequencer;
  localparam int PIPE_LAT = 12;
  localparam int DATA_W   = 18;
  localparam int SGN_W    = 10;
  localparam int TAG_W    = 4;
  localparam int ENT_W    = TAG_W + DATA_W + SGN_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic [DATA_W-1:0] pipe_d6 = '0;
  logic [SGN_W-1:0]  pipe_sgn = '0;

  logic a_in_ready, a_pipe_issue, a_out_valid, a_busy, a_ovf_err;
  logic [TAG_W-1:0] a_out_tag; logic [DATA_W-1:0] a_out_d6; logic [SGN_W-1:0] a_out_sgn;
  logic b_in_ready, b_pipe_issue, b_out_valid, b_busy, b_ovf_err;
  logic [TAG_W-1:0] b_out_tag; logic [DATA_W-1:0] b_out_d6; logic [SGN_W-1:0] b_out_sgn;

  mrc_pipe_sequencer #(.PIPE_LAT(PIPE_LAT), .DATA_W(DATA_W), .SGN_W(SGN_W), .TAG_W(TAG_W), .FIFO_DEPTH(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_tag(in_tag), .in_ready(a_in_ready),
    .flush(flush), .pipe_issue(a_pipe_issue), .pipe_d6(pipe_d6), .pipe_sgn(pipe_sgn),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_tag(a_out_tag), .out_d6(a_out_d6),
    .out_sgn(a_out_sgn), .busy(a_busy), .ovf_err(a_ovf_err));

  mrc_pipe_sequencer #(.PIPE_LAT(PIPE_LAT), .DATA_W(DATA_W), .SGN_W(SGN_W), .TAG_W(TAG_W), .FIFO_DEPTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_tag(in_tag), .in_ready(b_in_ready),
    .flush(flush), .pipe_issue(b_pipe_issue), .pipe_d6(pipe_d6), .pipe_sgn(pipe_sgn),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_tag(b_out_tag), .out_d6(b_out_d6),
    .out_sgn(b_out_sgn), .busy(b_busy), .ovf_err(b_ovf_err));

  always #5 clk = ~clk;

  // Transaction model: words in flight with their due cycle, and the queue of captured results.
  typedef struct { int due; logic [TAG_W-1:0] tag; } fl_t;
  typedef struct { logic [TAG_W-1:0] tag; logic [DATA_W-1:0] d6; logic [SGN_W-1:0] sgn; } res_t;
  fl_t  m_fl[$];
  res_t m_q[$];
  int   cyc = 0;
  int   m_depth = 8;
  int   n_cmp = 0, n_bad = 0;

  function automatic logic m_ready();
    return ((m_depth - m_fl.size() - m_q.size()) != 0) && !flush;
  endfunction

  function automatic logic m_busy();
    return (m_fl.size() != 0) || (m_q.size() != 0);
  endfunction

  function automatic logic [ENT_W:0] m_head();
    if (m_q.size() == 0) return '0;
    return {1'b1, m_q[0].tag, m_q[0].d6, m_q[0].sgn};
  endfunction

  task automatic tick();
    logic iss, cap, pp;
    res_t r;
    iss = in_valid && m_ready();
    cap = (m_fl.size() != 0) && (m_fl[0].due == cyc);
    pp  = (m_q.size() != 0) && out_ready;
    r.tag = cap ? m_fl[0].tag : '0;
    r.d6  = pipe_d6;
    r.sgn = pipe_sgn;
    @(posedge clk);
    if (flush) begin
      m_fl.delete();
      m_q.delete();
    end else begin
      if (pp) void'(m_q.pop_front());
      if (cap) begin m_q.push_back(r); void'(m_fl.pop_front()); end
      if (iss) m_fl.push_back('{cyc + PIPE_LAT, in_tag});
    end
    cyc++;
    @(negedge clk);
    pipe_d6  = DATA_W'($urandom);
    pipe_sgn = SGN_W'($urandom);
    in_tag   = TAG_W'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_fl.delete(); m_q.delete(); cyc = 0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1; in_valid = 1'b1;
    #1;
    n_cmp++;
    if ({a_in_ready, a_pipe_issue, a_out_valid, a_busy, a_ovf_err} !== 5'b11000) begin
      n_bad++; $display("FAIL reset_ctrl got=%b exp=%b", {a_in_ready, a_pipe_issue, a_out_valid, a_busy, a_ovf_err}, 5'b11000);
    end
    n_cmp++;
    if ({a_out_tag, a_out_d6, a_out_sgn} !== '0) begin
      n_bad++; $display("FAIL reset_data got=%h exp=0", {a_out_tag, a_out_d6, a_out_sgn});
    end
    in_valid = 1'b0;
    #1 n_cmp++;
    if (a_pipe_issue !== 1'b0) begin n_bad++; $display("FAIL reset_issue got=%b exp=0", a_pipe_issue); end
    m_depth = 8;
    do_reset();
  endtask

  task automatic test_single_word();
    m_depth = 8; do_reset(); out_ready = 1'b1;
    while (cyc < 18) begin
      in_valid = (cyc == 0);
      if (cyc == 0) in_tag = 4'h5;
      if (cyc == 12) pipe_d6 = 18'h2A5B1;
      #1;
      n_cmp++;
      if ({a_in_ready, a_pipe_issue, a_busy, a_ovf_err} !== {m_ready(), in_valid & m_ready(), m_busy(), 1'b0}) begin
        n_bad++; $display("FAIL single_status cyc=%0d got=%b exp=%b", cyc, {a_in_ready, a_pipe_issue, a_busy, a_ovf_err}, {m_ready(), in_valid & m_ready(), m_busy(), 1'b0});
      end
      n_cmp++;
      if ({a_out_valid, a_out_tag, a_out_d6, a_out_sgn} !== m_head()) begin
        n_bad++; $display("FAIL single_head cyc=%0d got=%h exp=%h", cyc, {a_out_valid, a_out_tag, a_out_d6, a_out_sgn}, m_head());
      end
      n_cmp++;
      if ({a_out_valid, a_out_valid ? {a_out_tag, a_out_d6} : 22'h0} !== ((cyc == 13) ? {1'b1, 4'h5, 18'h2A5B1} : 23'h0)) begin
        n_bad++; $display("FAIL single_fixed cyc=%0d got=%b/%h/%h", cyc, a_out_valid, a_out_tag, a_out_d6);
      end
      if (cyc == 14) begin
        n_cmp++;
        if (a_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy cyc=14 got=%b exp=0", a_busy); end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    int outs = 0;
    m_depth = 16; do_reset(); out_ready = 1'b1;
    while (cyc < 58) begin
      in_valid = (cyc < 40);
      in_tag = TAG_W'(cyc % 16);
      #1;
      n_cmp++;
      if ({b_in_ready, b_pipe_issue, b_busy, b_ovf_err} !== {m_ready(), in_valid & m_ready(), m_busy(), 1'b0}) begin
        n_bad++; $display("FAIL stream_status cyc=%0d got=%b exp=%b", cyc, {b_in_ready, b_pipe_issue, b_busy, b_ovf_err}, {m_ready(), in_valid & m_ready(), m_busy(), 1'b0});
      end
      n_cmp++;
      if ({b_out_valid, b_out_tag, b_out_d6, b_out_sgn} !== m_head()) begin
        n_bad++; $display("FAIL stream_head cyc=%0d got=%h exp=%h", cyc, {b_out_valid, b_out_tag, b_out_d6, b_out_sgn}, m_head());
      end
      n_cmp++;
      if (b_out_valid !== (cyc >= 13 && cyc <= 52) || (b_out_valid && b_out_tag !== TAG_W'((cyc - 13) % 16))) begin
        n_bad++; $display("FAIL stream_order cyc=%0d got=%b/%h", cyc, b_out_valid, b_out_tag);
      end
      if (b_out_valid === 1'b1) outs++;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (outs != 40) begin n_bad++; $display("FAIL stream_count got=%0d exp=40", outs); end
  endtask

  task automatic test_backpressure();
    int n_iss = 0;
    m_depth = 8; do_reset();
    while (cyc < 64) begin
      in_valid = 1'b1;
      out_ready = (cyc >= 30);
      #1;
      n_cmp++;
      if ({a_in_ready, a_pipe_issue, a_busy, a_ovf_err} !== {m_ready(), in_valid & m_ready(), m_busy(), 1'b0}) begin
        n_bad++; $display("FAIL bp_status cyc=%0d got=%b exp=%b", cyc, {a_in_ready, a_pipe_issue, a_busy, a_ovf_err}, {m_ready(), in_valid & m_ready(), m_busy(), 1'b0});
      end
      n_cmp++;
      if ({a_out_valid, a_out_tag, a_out_d6, a_out_sgn} !== m_head()) begin
        n_bad++; $display("FAIL bp_head cyc=%0d got=%h exp=%h", cyc, {a_out_valid, a_out_tag, a_out_d6, a_out_sgn}, m_head());
      end
      if (cyc < 30 && a_pipe_issue === 1'b1) n_iss++;
      if (cyc == 30 || cyc == 31) begin
        n_cmp++;
        if (a_in_ready !== (cyc == 31)) begin n_bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, a_in_ready, cyc == 31); end
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n_iss != 8) begin n_bad++; $display("FAIL bp_issues got=%0d exp=8", n_iss); end
  endtask

  task automatic test_simultaneous();
    m_depth = 8; do_reset();
    while (cyc < 36) begin
      in_valid  = (cyc <= 6) || cyc == 13 || cyc == 14;
      in_tag    = TAG_W'(cyc + 1);
      out_ready = (cyc == 13) || (cyc >= 15);
      #1;
      n_cmp++;
      if ({a_in_ready, a_pipe_issue, a_busy, a_ovf_err} !== {m_ready(), in_valid & m_ready(), m_busy(), 1'b0}) begin
        n_bad++; $display("FAIL simul_status cyc=%0d got=%b exp=%b", cyc, {a_in_ready, a_pipe_issue, a_busy, a_ovf_err}, {m_ready(), in_valid & m_ready(), m_busy(), 1'b0});
      end
      n_cmp++;
      if ({a_out_valid, a_out_tag, a_out_d6, a_out_sgn} !== m_head()) begin
        n_bad++; $display("FAIL simul_head cyc=%0d got=%h exp=%h", cyc, {a_out_valid, a_out_tag, a_out_d6, a_out_sgn}, m_head());
      end
      if (cyc == 14) begin
        n_cmp++;
        if ({a_in_ready, a_out_valid, a_out_tag} !== {1'b1, 1'b1, 4'h2}) begin
          n_bad++; $display("FAIL simul_after cyc=14 got=%b/%b/%h exp=1/1/2", a_in_ready, a_out_valid, a_out_tag);
        end
      end
      if (cyc == 15) begin
        n_cmp++;
        if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL simul_full cyc=15 got=%b exp=0", a_in_ready); end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    m_depth = 8; do_reset();
    while (cyc < 32) begin
      in_valid  = (cyc <= 1) || (cyc >= 9 && cyc <= 15);
      if (cyc == 15) in_tag = 4'hA;
      flush     = (cyc == 14);
      out_ready = (cyc == 14);
      #1;
      n_cmp++;
      if ({a_in_ready, a_pipe_issue, a_busy, a_ovf_err} !== {m_ready(), in_valid & m_ready(), m_busy(), 1'b0}) begin
        n_bad++; $display("FAIL flush_status cyc=%0d got=%b exp=%b", cyc, {a_in_ready, a_pipe_issue, a_busy, a_ovf_err}, {m_ready(), in_valid & m_ready(), m_busy(), 1'b0});
      end
      n_cmp++;
      if ({a_out_valid, a_out_tag, a_out_d6, a_out_sgn} !== m_head()) begin
        n_bad++; $display("FAIL flush_head cyc=%0d got=%h exp=%h", cyc, {a_out_valid, a_out_tag, a_out_d6, a_out_sgn}, m_head());
      end
      if (cyc == 14) begin
        n_cmp++;
        if ({a_in_ready, a_pipe_issue, a_out_valid, a_busy} !== 4'b0011) begin
          n_bad++; $display("FAIL flush_cycle got=%b exp=0011", {a_in_ready, a_pipe_issue, a_out_valid, a_busy});
        end
      end
      if (cyc == 15) begin
        n_cmp++;
        if ({a_in_ready, a_out_valid, a_busy} !== 3'b100) begin
          n_bad++; $display("FAIL flush_after got=%b exp=100", {a_in_ready, a_out_valid, a_busy});
        end
      end
      if (cyc >= 16 && cyc <= 28) begin
        n_cmp++;
        if ({a_out_valid, a_out_valid ? a_out_tag : 4'h0} !== ((cyc == 28) ? 5'b1_1010 : 5'b0)) begin
          n_bad++; $display("FAIL flush_reissue cyc=%0d got=%b/%h", cyc, a_out_valid, a_out_tag);
        end
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    m_depth = 8; do_reset();
    while (cyc < 17) begin
      in_valid = (cyc <= 2);
      #1;
      n_cmp++;
      if ({a_out_valid, a_out_tag, a_out_d6, a_out_sgn} !== m_head()) begin
        n_bad++; $display("FAIL areset_fill cyc=%0d got=%h exp=%h", cyc, {a_out_valid, a_out_tag, a_out_d6, a_out_sgn}, m_head());
      end
      tick();
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 n_cmp++;
    if ({a_out_valid, a_busy, a_in_ready} !== 3'b001) begin
      n_bad++; $display("FAIL areset_mid got=%b exp=001", {a_out_valid, a_busy, a_in_ready});
    end
    @(negedge clk);
    reset = 1'b0; m_fl.delete(); m_q.delete(); cyc = 0; out_ready = 1'b1;
    while (cyc < 16) begin
      in_valid = (cyc == 0);
      if (cyc == 0) in_tag = 4'h3;
      #1;
      n_cmp++;
      if ({a_out_valid, a_out_tag, a_out_d6, a_out_sgn} !== m_head()) begin
        n_bad++; $display("FAIL areset_post cyc=%0d got=%h exp=%h", cyc, {a_out_valid, a_out_tag, a_out_d6, a_out_sgn}, m_head());
      end
      n_cmp++;
      if (a_out_valid !== (cyc == 13)) begin n_bad++; $display("FAIL areset_lat cyc=%0d got=%b exp=%b", cyc, a_out_valid, cyc == 13); end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    m_depth = 8; do_reset();
    while (cyc < 500) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(59) == 0);
      #1;
      n_cmp++;
      if ({a_in_ready, a_pipe_issue, a_busy, a_ovf_err} !== {m_ready(), in_valid & m_ready(), m_busy(), 1'b0}) begin
        n_bad++; $display("FAIL rand_status cyc=%0d got=%b exp=%b", cyc, {a_in_ready, a_pipe_issue, a_busy, a_ovf_err}, {m_ready(), in_valid & m_ready(), m_busy(), 1'b0});
      end
      n_cmp++;
      if ({a_out_valid, a_out_tag, a_out_d6, a_out_sgn} !== m_head()) begin
        n_bad++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", cyc, {a_out_valid, a_out_tag, a_out_d6, a_out_sgn}, m_head());
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
